pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 33 +++
 rtl/pipeline_ctrl.sv | 81 ++++++++
 tb/tb_pipeline_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/stall controller: FSM state codes,
// per-stage hold vectors and the prioritised stall selector.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Hold vectors, bit0 = PC ... bit5 = WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  function automatic logic [5:0] stall_sel(input logic mem_req,
                                           input logic ex_req,
                                           input logic id_req);
    logic [5:0] v;
    if (mem_req) begin
      v = STALL_MEM;
    end else if (ex_req) begin
      v = STALL_EX;
    end else if (id_req) begin
      v = STALL_ID;
    end else begin
      v = STALL_NONE;
    end
    return v;
  endfunction

endpackage

// File: rtl/pipeline_ctrl.sv
// Pipeline stall controller: merges ID/MEM hazard requests with a multi-cycle
// EX sequencer (IDLE -> RUN -> DONE) into one per-stage hold vector.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       stallreq_id_i,
  input  logic       stallreq_mem_i,
  input  logic       ex_multi_i,
  input  logic [5:0] ex_len_i,
  input  logic       ex_cancel_i,
  output logic [5:0] stall_o,
  output logic       ex_busy_o,
  output logic       ex_done_o,
  output logic [5:0] ex_count_o
);

  state_e     state_q, state_d;
  logic [5:0] count_q, count_d;
  logic       start_s;
  logic       ex_req_s;

  // Zero-length multi-cycle ops complete in a single EX cycle and never start the sequencer.
  assign start_s  = (state_q == ST_IDLE) && ex_multi_i && (ex_len_i != 6'd0) && !ex_cancel_i;
  assign ex_req_s = (state_q == ST_RUN) || start_s;

  assign stall_o    = stall_sel(stallreq_mem_i, ex_req_s, stallreq_id_i);
  assign ex_busy_o  = (state_q == ST_RUN);
  assign ex_done_o  = (state_q == ST_DONE);
  assign ex_count_o = count_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (ex_cancel_i) begin
      state_d = ST_IDLE;
      count_d = 6'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_s) begin
            state_d = ST_RUN;
            count_d = ex_len_i;
          end else begin
            count_d = 6'd0;
          end
        end
        ST_RUN: begin
          if (stallreq_mem_i) begin
            count_d = count_q;
          end else if (count_q <= 6'd1) begin
            state_d = ST_DONE;
            count_d = 6'd0;
          end else begin
            count_d = count_q - 6'd1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          count_d = 6'd0;
        end
        default: begin
          state_d = ST_IDLE;
          count_d = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= 6'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a per-cycle vector table plus hand-written
// multi-cycle sequences (divide, MEM overlap, cancel, back-to-back, reset).
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       stallreq_id_i, stallreq_mem_i, ex_multi_i, ex_cancel_i;
  logic [5:0] ex_len_i;
  logic [5:0] stall_o, ex_count_o;
  logic       ex_busy_o, ex_done_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id_i (stallreq_id_i),
    .stallreq_mem_i(stallreq_mem_i),
    .ex_multi_i    (ex_multi_i),
    .ex_len_i      (ex_len_i),
    .ex_cancel_i   (ex_cancel_i),
    .stall_o       (stall_o),
    .ex_busy_o     (ex_busy_o),
    .ex_done_o     (ex_done_o),
    .ex_count_o    (ex_count_o)
  );

  typedef struct {
    logic       r, id, mem, mul;
    logic [5:0] len;
    logic       can;
    logic [5:0] e_stall;
    logic       e_busy, e_done;
    logic [5:0] e_cnt;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  task automatic compare(input logic [5:0] es, input logic eb, input logic ed,
                         input logic [5:0] ec, input string nm);
    logic [13:0] act, exp;
    act = {stall_o, ex_busy_o, ex_done_o, ex_count_o};
    exp = {es, eb, ed, ec};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got stall=%b busy=%b done=%b cnt=%0d, want stall=%b busy=%b done=%b cnt=%0d",
               nm, stall_o, ex_busy_o, ex_done_o, ex_count_o, es, eb, ed, ec);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check, then advance to the next falling edge.
  task automatic cyc(input logic r, input logic id, input logic mem, input logic mul,
                     input logic [5:0] len, input logic can,
                     input logic [5:0] es, input logic eb, input logic ed,
                     input logic [5:0] ec, input string nm);
    rst = r; stallreq_id_i = id; stallreq_mem_i = mem;
    ex_multi_i = mul; ex_len_i = len; ex_cancel_i = can;
    #1;
    compare(es, eb, ed, ec, nm);
    @(negedge clk);
  endtask

  task automatic idle(input string nm);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b000000, 1'b0, 1'b0, 6'd0, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stallreq_id_i = 1'b0; stallreq_mem_i = 1'b0;
    ex_multi_i = 1'b0; ex_len_i = 6'd0; ex_cancel_i = 1'b0;

    //          r     id    mem   mul   len    can   stall        busy  done  cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b000000, 1'b0, 1'b0, 6'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'b000111, 1'b0, 1'b0, 6'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 6'b001111, 1'b0, 1'b0, 6'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b000000, 1'b0, 1'b0, 6'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'b000111, 1'b0, 1'b0, 6'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b000000, 1'b0, 1'b0, 6'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 6'b000000, 1'b0, 1'b0, 6'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b000000, 1'b0, 1'b0, 6'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'b011111, 1'b0, 1'b0, 6'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd2, 1'b0, 6'b011111, 1'b0, 1'b0, 6'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b001111, 1'b1, 1'b0, 6'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b001111, 1'b1, 1'b0, 6'd1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b000000, 1'b0, 1'b1, 6'd0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b000000, 1'b0, 1'b0, 6'd0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 1'b1, 6'b000000, 1'b0, 1'b0, 6'd0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b000000, 1'b0, 1'b0, 6'd0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd1, 1'b0, 6'b001111, 1'b0, 1'b0, 6'd0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b001111, 1'b1, 1'b0, 6'd1};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'b000111, 1'b0, 1'b1, 6'd0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b000000, 1'b0, 1'b0, 6'd0};

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      cyc(vecs[i].r, vecs[i].id, vecs[i].mem, vecs[i].mul, vecs[i].len, vecs[i].can,
          vecs[i].e_stall, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_cnt,
          $sformatf("vec%0d", i));
    end

    // Divide, length 32: 33 stall cycles, 32 busy, done in cycle 34.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 6'd32, 1'b0, 6'b001111, 1'b0, 1'b0, 6'd0, "div_issue");
    for (int k = 32; k >= 1; k--)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b001111, 1'b1, 1'b0, 6'(k),
          $sformatf("div_run%0d", k));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b000000, 1'b0, 1'b1, 6'd0, "div_done");
    idle("div_after");

    // MEM stall overlapping RUN at count 10 holds the count for 3 cycles.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 6'd12, 1'b0, 6'b001111, 1'b0, 1'b0, 6'd0, "mem_issue");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b001111, 1'b1, 1'b0, 6'd12, "mem_run12");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b001111, 1'b1, 1'b0, 6'd11, "mem_run11");
    for (int k = 0; k < 3; k++)
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'b011111, 1'b1, 1'b0, 6'd10,
          $sformatf("mem_hold%0d", k));
    for (int k = 10; k >= 1; k--)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b001111, 1'b1, 1'b0, 6'(k),
          $sformatf("mem_run%0d", k));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b000000, 1'b0, 1'b1, 6'd0, "mem_done");
    idle("mem_after");

    // Cancel at count 5: back to IDLE with no done pulse.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 6'd8, 1'b0, 6'b001111, 1'b0, 1'b0, 6'd0, "can_issue");
    for (int k = 8; k >= 6; k--)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b001111, 1'b1, 1'b0, 6'(k),
          $sformatf("can_run%0d", k));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 6'b001111, 1'b1, 1'b0, 6'd5, "can_assert");
    idle("can_idle0");
    idle("can_idle1");

    // Back-to-back length-4 ops; the next op is already presented during DONE.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 6'd4, 1'b0, 6'b001111, 1'b0, 1'b0, 6'd0, "b2b_issue1");
    for (int k = 4; k >= 1; k--)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b001111, 1'b1, 1'b0, 6'(k),
          $sformatf("b2b_runa%0d", k));
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 6'd4, 1'b0, 6'b000000, 1'b0, 1'b1, 6'd0, "b2b_done1");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 6'd4, 1'b0, 6'b001111, 1'b0, 1'b0, 6'd0, "b2b_issue2");
    for (int k = 4; k >= 1; k--)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b001111, 1'b1, 1'b0, 6'(k),
          $sformatf("b2b_runb%0d", k));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b000000, 1'b0, 1'b1, 6'd0, "b2b_done2");
    idle("b2b_idle0");
    idle("b2b_idle1");

    // Asynchronous reset mid-RUN at count 20.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 6'd25, 1'b0, 6'b001111, 1'b0, 1'b0, 6'd0, "rst_issue");
    for (int k = 25; k >= 21; k--)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b001111, 1'b1, 1'b0, 6'(k),
          $sformatf("rst_run%0d", k));
    rst = 1'b0; ex_multi_i = 1'b0; ex_len_i = 6'd0;
    #1;
    compare(6'b001111, 1'b1, 1'b0, 6'd20, "rst_run20");
    #1 rst = 1'b1;
    #1;
    compare(6'b000000, 1'b0, 1'b0, 6'd0, "rst_async");
    @(negedge clk);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b000000, 1'b0, 1'b0, 6'd0, "rst_held");
    idle("rst_rel0");
    idle("rst_rel1");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
